// File: rtl/adc_readout_pkg.sv
// rtl/adc_readout_pkg.sv - shared types and constants for the ADC row readout
package adc_readout_pkg;

    // Code width of the ADC row counters; the readout defaults to the same width
    localparam int unsigned ADC_DATA_W = 8;

    // One pixel code as produced by the ADC row
    typedef logic [ADC_DATA_W-1:0] pixel_code_t;

    // Readout sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/single_row_readout.sv
// rtl/single_row_readout.sv - snapshot a row of ADC codes and stream them over valid/ready
module single_row_readout
    import adc_readout_pkg::*;
#(
    parameter int NUM_PIXELS = 5,
    parameter int DATA_W     = ADC_DATA_W,
    localparam int IDX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [NUM_PIXELS-1:0][DATA_W-1:0] pixel_values,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [IDX_W-1:0]                 out_index,
    output logic                             out_last,
    output logic                             busy,
    output logic                             row_done,
    output logic                             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [DATA_W-1:0]   shadow_q [NUM_PIXELS];
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic                row_done_q;
    logic                overrun_q;
    logic                xfer;

    assign xfer = out_valid_q && out_ready;

    // Next pixel index; saturates on the last pixel so the shadow lookup never leaves the row
    assign idx_d = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;

    // Readout sequencer: snapshot on start, one pixel per transfer, one-cycle DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            row_done_q  <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    row_done_q <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < NUM_PIXELS; i++) begin
                            shadow_q[i] <= pixel_values[i];
                        end
                        idx_q       <= '0;
                        out_data_q  <= pixel_values[0];
                        out_last_q  <= (LAST_IDX == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    // A new conversion cannot be taken while the row drains; flag it and carry on
                    if (start) begin
                        overrun_q <= 1'b1;
                    end
                    if (xfer) begin
                        if (out_last_q) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            idx_q       <= '0;
                            row_done_q  <= 1'b1;
                        end else begin
                            idx_q      <= idx_d;
                            out_data_q <= shadow_q[idx_d];
                            out_last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        overrun_q <= 1'b1;
                    end
                    row_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign row_done  = row_done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_single_row_readout.sv
// tb/tb_single_row_readout.sv - directed self-checking bench for single_row_readout
module tb_single_row_readout;
    import adc_readout_pkg::*;

    logic clk;
    logic reset;

    logic            start;
    logic [4:0][7:0] pv;
    logic            ready;
    logic            valid;
    logic [7:0]      data;
    logic [2:0]      idx;
    logic            last;
    logic            busy;
    logic            done;
    logic            ovr;

    logic            start1;
    logic [0:0][7:0] pv1;
    logic            ready1;
    logic            valid1;
    logic [7:0]      data1;
    logic [0:0]      idx1;
    logic            last1;
    logic            busy1;
    logic            done1;
    logic            ovr1;

    int checks;
    int failures;

    single_row_readout #(.NUM_PIXELS(5), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .pixel_values(pv),
        .out_valid(valid), .out_ready(ready), .out_data(data), .out_index(idx),
        .out_last(last), .busy(busy), .row_done(done), .overrun(ovr)
    );

    single_row_readout #(.NUM_PIXELS(1), .DATA_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .pixel_values(pv1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1), .out_index(idx1),
        .out_last(last1), .busy(busy1), .row_done(done1), .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start1 = 1'b0; ready = 1'b1; ready1 = 1'b1;
        pv = '0; pv1 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || data !== 8'd0 || idx !== 3'd0 || last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%0d idx=%0d last=%b busy=%b done=%b ovr=%b, need all 0",
                     valid, data, idx, last, busy, done, ovr);
        end
        checks++;
        if (valid1 !== 1'b0 || data1 !== 8'd0 || idx1 !== 1'd0 || last1 !== 1'b0 ||
            busy1 !== 1'b0 || done1 !== 1'b0 || ovr1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_n1: valid=%b data=%0d idx=%0d last=%b busy=%b done=%b ovr=%b, need all 0",
                     valid1, data1, idx1, last1, busy1, done1, ovr1);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_row();
        logic [7:0] exp_d;
        pv = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_d = 8'(10 * (i + 1));
            checks++;
            if (valid !== 1'b1 || data !== exp_d || idx !== 3'(i) ||
                last !== (i == 4) || done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL basic_beat%0d: valid=%b data=%0d idx=%0d last=%b done=%b busy=%b, need 1 %0d %0d %b 0 1",
                         i, valid, data, idx, last, done, busy, exp_d, i, (i == 4));
            end
            @(negedge clk);
        end
        checks++;
        if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_done: valid=%b done=%b busy=%b, need 0 1 1", valid, done, busy);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: valid=%b done=%b busy=%b, need 0 0 0", valid, done, busy);
        end
    endtask

    task automatic test_backpressure();
        int         exp_idx [8] = '{0, 1, 2, 2, 2, 2, 3, 4};
        logic       rdy     [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_d;
        pv = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp_d = 8'(10 * (exp_idx[c] + 1));
            checks++;
            if (valid !== 1'b1 || data !== exp_d || idx !== 3'(exp_idx[c]) ||
                last !== (exp_idx[c] == 4)) begin
                failures++;
                $display("FAIL backpressure_cyc%0d: valid=%b data=%0d idx=%0d last=%b, need 1 %0d %0d %b",
                         c, valid, data, idx, last, exp_d, exp_idx[c], (exp_idx[c] == 4));
            end
            ready = rdy[c];
            @(negedge clk);
        end
        ready = 1'b1;
        checks++;
        if (valid !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_done: valid=%b done=%b, need 0 1", valid, done);
        end
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pv = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pv = {5{8'hFF}};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== exp_d[i] || idx !== 3'(i)) begin
                failures++;
                $display("FAIL snapshot_beat%0d: valid=%b data=%h idx=%0d, need 1 %h %0d",
                         i, valid, data, idx, exp_d[i], i);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL snapshot_done: done=%b, need 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        checks++;
        if (ovr !== 1'b0) begin
            failures++;
            $display("FAIL overrun_before: ovr=%b, need 0", ovr);
        end
        pv = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== 8'(i + 1) || idx !== 3'(i) || ovr !== (i >= 2)) begin
                failures++;
                $display("FAIL overrun_beat%0d: valid=%b data=%0d idx=%0d ovr=%b, need 1 %0d %0d %b",
                         i, valid, data, idx, ovr, i + 1, i, (i >= 2));
            end
            start = (i == 1 || i == 4);
            pv = (i == 1 || i == 4) ? {5{8'hEE}} : {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || done !== 1'b1 || ovr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_done: valid=%b done=%b ovr=%b, need 0 1 1", valid, done, ovr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || ovr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_no_second_row: valid=%b busy=%b ovr=%b, need 0 0 1", valid, busy, ovr);
        end
    endtask

    task automatic test_reset_mid_row();
        pv = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || idx !== 3'd3 || data !== 8'd40) begin
            failures++;
            $display("FAIL midrow_pre: valid=%b idx=%0d data=%0d, need 1 3 40", valid, idx, data);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (valid !== 1'b0 || data !== 8'd0 || idx !== 3'd0 || last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
            failures++;
            $display("FAIL midrow_reset: valid=%b data=%0d idx=%0d last=%b busy=%b done=%b ovr=%b, need all 0",
                     valid, data, idx, last, busy, done, ovr);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrow_no_done: valid=%b done=%b, need 0 0", valid, done);
        end
        pv = {8'd11, 8'd10, 8'd9, 8'd8, 8'd7};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== 8'(i + 7) || idx !== 3'(i) || last !== (i == 4)) begin
                failures++;
                $display("FAIL midrow_restart_beat%0d: valid=%b data=%0d idx=%0d last=%b, need 1 %0d %0d %b",
                         i, valid, data, idx, last, i + 7, i, (i == 4));
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL midrow_restart_done: done=%b, need 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        pixel_code_t code;
        code = 8'hA5;
        pv1 = code;
        ready1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        pv1 = '0;
        checks++;
        if (valid1 !== 1'b1 || data1 !== 8'hA5 || idx1 !== 1'd0 || last1 !== 1'b1) begin
            failures++;
            $display("FAIL n1_beat: valid=%b data=%h idx=%0d last=%b, need 1 a5 0 1",
                     valid1, data1, idx1, last1);
        end
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b0 || done1 !== 1'b1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL n1_done: valid=%b done=%b busy=%b, need 0 1 1", valid1, done1, busy1);
        end
        @(negedge clk);
        checks++;
        if (valid1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL n1_idle: valid=%b done=%b busy=%b, need 0 0 0", valid1, done1, busy1);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_row();
        test_backpressure();
        test_snapshot();
        test_overrun();
        test_reset_mid_row();
        test_single_pixel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/single_row_readout.md
Name: single_row_readout

Overview:
Reader side of the single-row single-slope ADC. On a conversion-done pulse it snapshots all per-pixel 8-bit counter codes into shadow registers. It then streams them out one pixel per transfer over a valid/ready interface, toward the frame packer or capture FIFO. Because of the snapshot, the ADC can start the next ramp while the previous row is still draining.

Parameters:
NUM_PIXELS, 5, number of pixels (comparators) in the row; must be >= 1
DATA_W, 8, width of each pixel code, matching the ADC counter width
IDX_W, max(1,$clog2(NUM_PIXELS)), width of the pixel index (derived localparam, not overridable)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: conversion complete, pixel_values valid this cycle
pixel_values  input  NUM_PIXELS x DATA_W  per-pixel stored codes from the ADC row
out_valid  output  1  out_data/out_index/out_last hold a valid pixel
out_ready  input  1  downstream accepts the pixel when high together with out_valid
out_data  output  DATA_W  pixel code
out_index  output  IDX_W  pixel number, 0 .. NUM_PIXELS-1
out_last  output  1  high with the final pixel of the row (index NUM_PIXELS-1)
busy  output  1  readout in progress (state != IDLE)
row_done  output  1  one-cycle pulse after the last pixel transfer
overrun  output  1  sticky: a start arrived while busy

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, row_done=0, overrun=0, shadow registers=0.
- Reset mid-row: the row is abandoned. No row_done is produced and the shadow contents are cleared.
- Transfer rule: a transfer occurs on any clk edge where out_valid && out_ready.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1: capture all pixel_values into the shadow registers on that edge, set index=0, go to SEND.
  - start=0: stay in IDLE.
  - Latency: start at cycle N -> out_valid=1 with pixel 0 at cycle N+1.
- SEND:
  - out_valid=1 throughout.
  - out_data = shadow[index]; out_last = (index == NUM_PIXELS-1).
  - On a transfer with out_last=0: index increments by 1.
  - On a transfer with out_last=1: go to DONE, out_valid drops next cycle.
  - Without a transfer: out_data, out_index and out_last hold stable, and out_valid must not drop.
- DONE: lasts one cycle with row_done=1 and out_valid=0, then returns to IDLE.
- Throughput: a row needs NUM_PIXELS+2 cycles minimum with out_ready tied high.
- start while busy:
  - Applies in SEND and DONE, including the cycle of the final transfer.
  - The start is ignored: no new snapshot, the current row continues unchanged.
  - overrun is set to 1 and stays set until reset.
- pixel_values is sampled only on an accepted start. Changes at any other time have no effect on the output.
- NUM_PIXELS=1: the first pixel has out_last=1 and index 0.
- Index never exceeds NUM_PIXELS-1. No wrap occurs, because the FSM leaves SEND on the last pixel.
- No arithmetic on pixel data; codes pass through bit-exact.

Decomposition:
- Shared package adc_readout_pkg holds:
  - the FSM state typedef (IDLE, SEND, DONE);
  - the DATA_W default constant, shared with the ADC row;
  - a pixel-code typedef logic [DATA_W-1:0].
- No sub-module. Shadow registers, index counter and FSM stay in one module; the shadow bank is a plain register array.

Test Plan:
- Basic row: out_ready=1, pixel_values={10,20,30,40,50}, start pulse at cycle N -> out_valid at N+1..N+5 with data 10,20,30,40,50 and index 0..4, out_last only at index 4, row_done at N+6, busy low at N+7.
- Backpressure: out_ready low for 3 cycles while index=2 -> out_data=30 and index=2 held stable with out_valid=1; the stream resumes at 40 when out_ready rises.
- Snapshot isolation: change pixel_values to all 8'hFF one cycle after start -> the output still streams the original codes.
- Overrun: start pulsed during SEND (index=1) and again on the final-transfer cycle -> the stream is unaffected, overrun=1 stays set, and no second row is emitted.
- Reset mid-row: assert reset while index=3 -> the next cycle shows all outputs 0 and no row_done. A start after reset streams the new values starting at index 0.
- NUM_PIXELS=1 build, value 8'hA5 -> a single beat with out_last=1 and index 0, then row_done.
